psum_accumulator: RTL

- Sits directly downstream of the output FIFO in the corelet and drives the PMEM/output SRAM port (128-bit, 9-bit address).
- For each of the 9 kernel positions (kij pass), it pops NPIX partial-sum vectors from the OFIFO and accumulates them into PMEM with a read-modify-write.
- On the final pass it applies ReLU and writes the finished output vectors back to the same addresses.
- Controlled by the corelet FSM through a start/pass_done handshake.

---
 rtl/corelet_pkg.sv | 24 ++
 rtl/psum_accumulator_lane.sv | 28 ++
 rtl/psum_accumulator.sv | 132 +++++++++++++
 3 files changed

// File: rtl/corelet_pkg.sv
// Shared corelet definitions: accumulator FSM states, vector geometry and
// single-port SRAM control encodings.
package corelet_pkg;

    localparam int COL      = 8;
    localparam int PSUM_BW  = 16;
    localparam int NPIX     = 16;
    localparam int KIJ_LAST = 8;
    localparam int ADDR_W   = 9;

    localparam logic CEN_ON  = 1'b0;
    localparam logic CEN_OFF = 1'b1;
    localparam logic WEN_WR  = 1'b0;
    localparam logic WEN_RD  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ADD,
        WRITE,
        DONE
    } acc_state_t;

endpackage

// File: rtl/psum_accumulator_lane.sv
// One accumulator lane: signed saturating add with optional ReLU clamp.
module psum_lane_sat_add #(
    parameter int W = corelet_pkg::PSUM_BW
) (
    input  logic signed [W-1:0] a,
    input  logic signed [W-1:0] b,
    input  logic                relu_en,
    output logic signed [W-1:0] y
);

    localparam logic [W-1:0] SAT_MAX = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] SAT_MIN = {1'b1, {(W-1){1'b0}}};

    logic signed [W:0] sum_ext;

    // NOTE: y is assigned unconditionally before any override, so no latch can be inferred.
    always_comb begin
        sum_ext = $signed({a[W-1], a}) + $signed({b[W-1], b});
        y = sum_ext[W-1:0];
        if (sum_ext[W] != sum_ext[W-1]) begin
            y = sum_ext[W] ? SAT_MIN : SAT_MAX;
        end
        if (relu_en && y[W-1]) begin
            y = '0;
        end
    end

endmodule

// File: rtl/psum_accumulator.sv
// Partial-sum accumulator between the OFIFO and PMEM: one read-modify-write
// per vector for each kij pass, with ReLU applied on the final pass.
module psum_accumulator #(
    parameter int COL       = corelet_pkg::COL,
    parameter int PSUM_BW   = corelet_pkg::PSUM_BW,
    parameter int NPIX      = corelet_pkg::NPIX,
    parameter int KIJ_LAST  = corelet_pkg::KIJ_LAST,
    parameter int BASE_ADDR = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [3:0]               kij,
    output logic                     busy,
    output logic                     pass_done,
    input  logic                     fifo_valid,
    input  logic [COL*PSUM_BW-1:0]   fifo_data,
    output logic                     fifo_rd,
    input  logic [COL*PSUM_BW-1:0]   mem_q,
    output logic [COL*PSUM_BW-1:0]   mem_d,
    output logic [8:0]               mem_addr,
    output logic                     mem_cen,
    output logic                     mem_wen
);

    import corelet_pkg::*;

    localparam int VW = COL * PSUM_BW;

    if (NPIX < 1 || BASE_ADDR < 0 || BASE_ADDR + NPIX > 512) begin : g_bad_cfg
        $error("psum_accumulator: BASE_ADDR + NPIX must lie within the 512-entry PMEM");
    end

    acc_state_t      state;
    logic [8:0]      idx;
    logic [3:0]      kij_r;
    logic [VW-1:0]   data_r;
    logic [VW-1:0]   sum_r;
    logic [VW-1:0]   lane_a;
    logic [VW-1:0]   lane_b;
    logic [VW-1:0]   lane_sum;
    logic [8:0]      cur_addr;
    logic            take;
    logic            first_pass;
    logic            is_final;
    logic            last_idx;

    assign take       = (state == FETCH) && fifo_valid;
    assign first_pass = (kij_r == 4'd0);
    assign is_final   = (kij_r == 4'(KIJ_LAST));
    assign last_idx   = (idx == 9'(NPIX - 1));
    assign cur_addr   = 9'(BASE_ADDR) + idx;

    // The first pass has no PMEM history: the popped vector goes through with a zero addend.
    assign lane_a = (state == ADD) ? mem_q  : fifo_data;
    assign lane_b = (state == ADD) ? data_r : '0;

    for (genvar i = 0; i < COL; i++) begin : g_lane
        psum_lane_sat_add #(.W(PSUM_BW)) u_lane (
            .a       (lane_a[i*PSUM_BW +: PSUM_BW]),
            .b       (lane_b[i*PSUM_BW +: PSUM_BW]),
            .relu_en (is_final),
            .y       (lane_sum[i*PSUM_BW +: PSUM_BW])
        );
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            kij_r <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        kij_r <= kij;
                        idx   <= '0;
                        state <= FETCH;
                    end
                end
                FETCH: begin
                    if (fifo_valid) begin
                        state <= first_pass ? WRITE : ADD;
                    end
                end
                ADD:   state <= WRITE;
                WRITE: begin
                    if (last_idx) begin
                        state <= DONE;
                    end else begin
                        idx   <= idx + 9'd1;
                        state <= FETCH;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // NOTE: datapath registers have no reset; each is written before it is ever observed.
    always_ff @(posedge clk) begin
        if (take) begin
            data_r <= fifo_data;
        end
        if ((take && first_pass) || state == ADD) begin
            sum_r <= lane_sum;
        end
    end

    always_comb begin
        busy      = (state inside {FETCH, ADD, WRITE});
        pass_done = (state == DONE);
        fifo_rd   = take;
        mem_cen   = CEN_OFF;
        mem_wen   = WEN_RD;
        mem_addr  = '0;
        mem_d     = '0;
        if (take && !first_pass) begin
            mem_cen  = CEN_ON;
            mem_addr = cur_addr;
        end
        if (state == WRITE) begin
            mem_cen  = CEN_ON;
            mem_wen  = WEN_WR;
            mem_addr = cur_addr;
            mem_d    = sum_r;
        end
    end

endmodule
